// File: rtl/pwm_burst_seq.sv
// Burst sequencer: fires burst_count one-cycle pwm_en strobes, waits for each pulse_valid,
// and idles gap_period cycles between pulses. Abort and pulse timeout cancel the burst.
module pwm_burst_seq #(
    parameter int _RAM_WIDTH     = 32,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  io_clk,
    input  logic                  io_rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CNT_WIDTH-1:0]  burst_count,
    input  logic [_RAM_WIDTH-1:0] pulse_period_in,
    input  logic [_RAM_WIDTH-1:0] die_period_in,
    input  logic [_RAM_WIDTH-1:0] gap_period,
    input  logic                  default_level_in,
    input  logic                  pulse_valid,
    output logic                  pwm_en,
    output logic                  pwm_dis,
    output logic [_RAM_WIDTH-1:0] pulse_period,
    output logic [_RAM_WIDTH-1:0] die_period,
    output logic                  io_defaultLevel,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  pulse_cnt,
    output logic                  err_timeout
);

    localparam int RW = _RAM_WIDTH;
    localparam int CW = CNT_WIDTH;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FIRE,
        WAIT,
        GAP,
        DONE
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_burst;
    logic [RW-1:0]  r_gap;
    logic [RW-1:0]  r_gap_cnt;
    logic [TW-1:0]  r_to_cnt;
    logic [CW-1:0]  w_new_cnt;
    logic           w_accept;
    logic           w_abort;
    logic           w_count;
    logic           w_timeout;

    always_comb begin
        w_next    = r_state;
        w_new_cnt = pulse_cnt + CW'(1);
        w_accept  = (r_state == IDLE) && start && !abort;
        w_abort   = abort && (r_state != IDLE);
        w_count   = (r_state == WAIT) && pulse_valid && !abort;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: if (w_accept) w_next = (burst_count == '0) ? DONE : FIRE;
            FIRE: w_next = WAIT;
            WAIT: begin
                if (pulse_valid) begin
                    if (w_new_cnt == r_burst)  w_next = DONE;
                    else if (r_gap == '0)      w_next = FIRE;
                    else                       w_next = GAP;
                end else if (r_to_cnt >= TO_LAST) begin
                    w_timeout = !abort;
                    w_next    = IDLE;
                end
            end
            GAP:  if (r_gap_cnt <= RW'(1)) w_next = FIRE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_abort) w_next = IDLE;
    end

    // r_to_cnt counts cycles since the pwm_en strobe, the FIRE cycle included.
    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            r_state         <= IDLE;
            r_burst         <= '0;
            r_gap           <= '0;
            r_gap_cnt       <= '0;
            r_to_cnt        <= '0;
            pwm_en          <= 1'b0;
            pwm_dis         <= 1'b0;
            pulse_period    <= '0;
            die_period      <= '0;
            io_defaultLevel <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pulse_cnt       <= '0;
            err_timeout     <= 1'b0;
        end else begin
            r_state <= w_next;
            pwm_en  <= (w_next == FIRE);
            busy    <= (w_next != IDLE);
            done    <= (r_state == DONE) && !w_abort;
            if (w_accept) begin
                r_burst         <= burst_count;
                r_gap           <= gap_period;
                pulse_period    <= pulse_period_in;
                die_period      <= die_period_in;
                io_defaultLevel <= default_level_in;
                pulse_cnt       <= '0;
                err_timeout     <= 1'b0;
                pwm_dis         <= 1'b0;
            end
            if (w_count) pulse_cnt <= w_new_cnt;
            if (w_abort || w_timeout) pwm_dis <= 1'b1;
            if (w_timeout) err_timeout <= 1'b1;
            if (r_state == FIRE)      r_to_cnt <= TW'(1);
            else if (r_state == WAIT) r_to_cnt <= r_to_cnt + TW'(1);
            if (r_state == WAIT && w_next == GAP) r_gap_cnt <= r_gap;
            else if (r_state == GAP)              r_gap_cnt <= r_gap_cnt - RW'(1);
        end
    end

endmodule

// File: tb/tb_pwm_burst_seq.sv
// Bench for pwm_burst_seq: pulse stub plus an arithmetic timeline model of each burst.
module tb_pwm_burst_seq;
    localparam int RW = 32;
    localparam int CW = 16;
    localparam int TO = 20;

    logic          io_clk = 1'b0;
    logic          io_rst, start, abort, pulse_valid, default_level_in;
    logic [CW-1:0] burst_count;
    logic [RW-1:0] pulse_period_in, die_period_in, gap_period;
    logic          pwm_en, pwm_dis, io_defaultLevel, busy, done, err_timeout;
    logic [RW-1:0] pulse_period, die_period;
    logic [CW-1:0] pulse_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int pend = -1;
    int stub_lat = 0;
    int en_q[$];
    int done_q[$];
    int pv_q[$];

    pwm_burst_seq #(._RAM_WIDTH(RW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
        .io_clk(io_clk), .io_rst(io_rst), .start(start), .abort(abort),
        .burst_count(burst_count), .pulse_period_in(pulse_period_in),
        .die_period_in(die_period_in), .gap_period(gap_period),
        .default_level_in(default_level_in), .pulse_valid(pulse_valid),
        .pwm_en(pwm_en), .pwm_dis(pwm_dis), .pulse_period(pulse_period),
        .die_period(die_period), .io_defaultLevel(io_defaultLevel), .busy(busy),
        .done(done), .pulse_cnt(pulse_cnt), .err_timeout(err_timeout)
    );

    always #5 io_clk = ~io_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: sample outputs at the falling edge, then drive this cycle's inputs.
    task automatic step();
        @(negedge io_clk);
        cyc++;
        start = 1'b0;
        abort = 1'b0;
        if (pwm_en === 1'b1) begin
            en_q.push_back(cyc);
            if (stub_lat > 0) pend = cyc + stub_lat;
        end
        if (done === 1'b1) done_q.push_back(cyc);
        pulse_valid = (cyc == pend);
        if (pulse_valid) pv_q.push_back(cyc);
    endtask

    task automatic clear_q();
        en_q.delete();
        done_q.delete();
        pv_q.delete();
        pend = -1;
    endtask

    task automatic run_burst(input int n, input int lat, input int g);
        int s, t, exp_done, fin;
        int exp_en[$];
        logic [RW-1:0] ep, ed;
        logic el;
        clear_q();
        stub_lat = lat;
        ep = $urandom;
        ed = $urandom;
        el = 1'($urandom_range(0, 1));
        pulse_period_in  = ep;
        die_period_in    = ed;
        default_level_in = el;
        gap_period       = RW'(g);
        burst_count      = CW'(n);
        start            = 1'b1;
        s = cyc;
        t = s + 1;
        for (int i = 0; i < n; i++) begin
            exp_en.push_back(t);
            t = t + lat + 1 + g;
        end
        exp_done = (n == 0) ? s + 2 : exp_en[n-1] + lat + 2;
        fin = 0;
        for (int k = 0; k < 600 && fin == 0; k++) begin
            step();
            if (done === 1'b1) begin
                chk("busy_at_done", busy, 0);
                chk("cnt_at_done", pulse_cnt, n);
                fin = 1;
            end else if (busy === 1'b1 && $urandom_range(0, 3) == 0) begin
                start            = 1'b1;
                burst_count      = CW'($urandom);
                pulse_period_in  = $urandom;
                die_period_in    = $urandom;
                gap_period       = $urandom;
                default_level_in = ~default_level_in;
            end
        end
        chk("done_seen", fin, 1);
        step();
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
        chk("en_count", en_q.size(), n);
        for (int i = 0; i < n && i < en_q.size(); i++) chk("en_time", en_q[i], exp_en[i]);
        chk("done_time", (done_q.size() > 0) ? done_q[0] : -1, exp_done);
        chk("pulse_period", pulse_period, ep);
        chk("die_period", die_period, ed);
        chk("default_level", io_defaultLevel, el);
        chk("pwm_dis_clear", pwm_dis, 0);
        chk("err_clear", err_timeout, 0);
        pulse_valid = 1'b1;
        step();
        step();
        chk("stray_pv_ignored", pulse_cnt, n);
    endtask

    initial begin
        int f;
        io_rst = 1'b1;
        start = 0; abort = 0; pulse_valid = 0; default_level_in = 0;
        burst_count = '0; pulse_period_in = '0; die_period_in = '0; gap_period = '0;
        step();
        step();
        chk("rst_pwm_en", pwm_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", pulse_cnt, 0);
        chk("rst_dis_err", {pwm_dis, err_timeout, io_defaultLevel}, 0);
        io_rst = 1'b0;
        step();

        run_burst(3, 10, 0);
        if (en_q.size() == 3) chk("spacing_11", en_q[2] - en_q[1], 11);
        run_burst(2, 7, 5);
        if (en_q.size() == 2 && pv_q.size() > 0) chk("gap_spacing_6", en_q[1] - pv_q[0], 6);
        run_burst(0, 5, 0);
        for (int r = 0; r < 8; r++)
            run_burst($urandom_range(1, 5), $urandom_range(1, 15), $urandom_range(0, 6));

        // Abort in idle, and start+abort together, do nothing.
        abort = 1'b1;
        step();
        burst_count = 2; start = 1'b1; abort = 1'b1;
        clear_q();
        step();
        step();
        chk("idle_abort_dis", pwm_dis, 0);
        chk("start_abort_busy", busy, 0);
        chk("start_abort_en", en_q.size(), 0);

        // Abort coincident with the 2nd of 4 pulse_valid strobes.
        clear_q();
        stub_lat = 3; burst_count = 4; gap_period = 2; start = 1'b1;
        for (int k = 0; k < 200 && pv_q.size() < 2; k++) step();
        chk("abort_reach_pv2", pv_q.size(), 2);
        abort = 1'b1;
        step();
        chk("abort_cnt", pulse_cnt, 1);
        chk("abort_dis", pwm_dis, 1);
        chk("abort_busy", busy, 0);
        repeat (10) step();
        chk("abort_dis_held", pwm_dis, 1);
        chk("abort_no_done", done_q.size(), 0);
        chk("abort_en_count", en_q.size(), 2);
        run_burst(1, 4, 0);

        // Stub never answers: timeout 20 cycles after pwm_en.
        clear_q();
        stub_lat = 0; burst_count = 2; gap_period = 0; start = 1'b1;
        for (int k = 0; k < 50 && en_q.size() == 0; k++) step();
        chk("to_en_seen", en_q.size(), 1);
        f = (en_q.size() > 0) ? en_q[0] : cyc;
        for (int k = 0; k < 40 && cyc < f + 19; k++) step();
        chk("to_not_early", err_timeout, 0);
        step();
        chk("to_err", err_timeout, 1);
        chk("to_dis", pwm_dis, 1);
        chk("to_busy", busy, 0);
        repeat (5) step();
        chk("to_no_done", done_q.size(), 0);
        chk("to_en_once", en_q.size(), 1);
        run_burst(2, 3, 1);

        // Reset asserted mid-GAP, between clock edges.
        clear_q();
        stub_lat = 4; burst_count = 3; gap_period = 8; start = 1'b1;
        pulse_period_in = 32'h1234_5678; die_period_in = 32'h9;
        for (int k = 0; k < 100 && pv_q.size() < 1; k++) step();
        repeat (3) step();
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_cnt", pulse_cnt, 1);
        #2;
        io_rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_cnt", pulse_cnt, 0);
        chk("arst_period", pulse_period, 0);
        chk("arst_die", die_period, 0);
        chk("arst_flags", {pwm_en, pwm_dis, done, err_timeout, io_defaultLevel}, 0);
        repeat (3) step();
        io_rst = 1'b0;
        clear_q();
        repeat (40) step();
        chk("post_rst_no_en", en_q.size(), 0);
        chk("post_rst_no_done", done_q.size(), 0);
        chk("post_rst_cnt", pulse_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end
endmodule
